// File: rtl/comm_pkg.sv
// Shared types and constants for the host-side UART command bridge.
// Holds the TX/RX state encodings, the 8N1 frame layout and a small
// helper that builds a transmit frame from a data byte.
package comm_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HIGH,
    TX_LOW
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // 8N1 frame, LSB is shifted out first: {stop, d7..d0, start}
  function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
    return {STOP_BIT, data, START_BIT};
  endfunction

endpackage

// File: rtl/comm_uart_rx.sv
// Purpose: 8N1 UART receiver with glitch-rejecting start detect and a sticky response register.
// Latency: resp_o/resp_rdy_o update on the stop-bit sample, ~9.5 bit times + 3 cycles after the start edge.
// Backpressure: none; a new good byte overwrites resp_o and keeps resp_rdy_o set (overrun).
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   rx_i          serial input, asynchronous to clk
//   clr_rdy_i     clears resp_rdy_o; a simultaneous set wins
//   resp_o        last byte received with a good stop bit
//   resp_rdy_o    set when resp_o is updated, held until cleared
module comm_uart_rx
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       clr_rdy_i,
  output logic [7:0] resp_o,
  output logic       resp_rdy_o
);

  localparam int              CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  logic [1:0]  sync_q;
  logic        prev_q;
  logic        rx_s;
  logic        fall;

  rx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  resp_q, resp_d;
  logic        rdy_q, rdy_d;
  logic        rdy_set;

  assign rx_s = sync_q[1];
  // prev_q trails the synchronized line by one cycle, so this is a clean 1->0 edge
  assign fall = prev_q & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      resp_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      resp_q  <= resp_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    resp_d  = resp_q;
    rdy_set = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit sample; a line that is already high again was a glitch
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 4'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          // Framing errors drop the byte silently
          if (rx_s == STOP_BIT) begin
            resp_d  = shift_q;
            rdy_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    rdy_d = rdy_set ? 1'b1 : (clr_rdy_i ? 1'b0 : rdy_q);
  end

  assign resp_o     = resp_q;
  assign resp_rdy_o = rdy_q;

endmodule

// File: rtl/comm_master.sv
// Purpose: host-side UART bridge; sends a 16-bit command as two 8N1 bytes (high first), receives response bytes.
// Latency: snd_cmd to cmd_cmplt is 20*BAUD_DIV+1 cycles; TX start bit appears the cycle after acceptance.
// Backpressure: snd_cmd is dropped (not queued) while busy, including the cmd_cmplt cycle.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   cmd, snd_cmd  command word and its 1-cycle send request
//   cmd_cmplt     1-cycle pulse after the low byte's stop bit
//   busy          high from accepted snd_cmd through cmd_cmplt
//   TX / RX       serial out (idles high) / serial in (asynchronous)
//   resp, resp_rdy, clr_resp_rdy   received byte, sticky flag, flag clear
module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_cmplt,
  output logic        busy,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic [FRAME_BITS-1:0]  frame_q, frame_d;
  logic [7:0]             lo_q, lo_d;
  logic                   cmplt_q, cmplt_d;
  logic                   bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      lo_q    <= '0;
      cmplt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      lo_q    <= lo_d;
      cmplt_q <= cmplt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    lo_d    = lo_q;
    cmplt_d = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        // cmplt_q keeps the bridge busy for one more cycle after returning to idle
        if (snd_cmd && !cmplt_q) begin
          state_d = TX_HIGH;
          frame_d = uart_frame(cmd[15:8]);
          lo_d    = cmd[7:0];
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      TX_HIGH, TX_LOW: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (state_q == TX_HIGH) begin
              // Low byte follows the high stop bit with no idle gap
              state_d = TX_LOW;
              frame_d = uart_frame(lo_q);
            end else begin
              state_d = TX_IDLE;
              cmplt_d = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            frame_d = {STOP_BIT, frame_q[FRAME_BITS-1:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Derived from state so reset forces the line high without waiting for a clock
  assign TX        = (state_q == TX_IDLE) ? STOP_BIT : frame_q[0];
  assign busy      = (state_q != TX_IDLE) | cmplt_q;
  assign cmd_cmplt = cmplt_q;

  comm_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (RX),
    .clr_rdy_i  (clr_resp_rdy),
    .resp_o     (resp),
    .resp_rdy_o (resp_rdy)
  );

endmodule

// File: tb/tb_comm_master.sv
module tb_comm_master;

  localparam int B     = 16;
  localparam int FRAME = 10 * B;
  localparam int LAT   = 20 * B + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        cmd_cmplt;
  logic        busy;
  logic        TX;
  logic        RX = 1'b1;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy = 1'b0;

  comm_master #(.BAUD_DIV(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd),
    .snd_cmd      (snd_cmd),
    .cmd_cmplt    (cmd_cmplt),
    .busy         (busy),
    .TX           (TX),
    .RX           (RX),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model / scoreboard state ----------------
  typedef struct {
    logic [7:0] data;
    int         start;
  } txb_t;

  txb_t       exp_tx_q[$];
  int         exp_cmplt_q[$];
  logic [7:0] exp_rx_q[$];

  bit         acc_vld = 0;
  int         acc_cyc = 0;
  logic [7:0] m_resp  = 8'h00;
  logic       m_rdy   = 1'b0;

  // Busy is visible from the cycle after acceptance through the cmd_cmplt cycle
  function automatic bit model_busy(input int c);
    return acc_vld && (c >= acc_cyc + 1) && (c <= acc_cyc + LAT);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_cmd(input logic [15:0] c);
    int   m;
    txb_t e;
    m = cyc;
    cmd = c;
    snd_cmd = 1'b1;
    if (!model_busy(m)) begin
      acc_vld = 1;
      acc_cyc = m;
      e.data = c[15:8]; e.start = m + 1;         exp_tx_q.push_back(e);
      e.data = c[7:0];  e.start = m + 1 + FRAME; exp_tx_q.push_back(e);
      exp_cmplt_q.push_back(m + LAT);
    end
    tick(1);
    snd_cmd = 1'b0;
    cmd = 16'($urandom);
  endtask

  task automatic wait_tx_done();
    int budget;
    budget = 0;
    while ((exp_tx_q.size() != 0 || exp_cmplt_q.size() != 0 || model_busy(cyc)) && budget < 3000) begin
      tick(1);
      budget++;
    end
    if (budget >= 3000) fail("tx_drain_timeout");
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_ok);
    if (stop_ok) begin
      exp_rx_q.push_back(d);
      m_resp = d;
      m_rdy  = 1'b1;
    end
    RX = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      tick(B);
    end
    RX = stop_ok;
    tick(B);
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_resp_rdy = 1'b1;
    tick(1);
    clr_resp_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  // ---------------- TX monitor: behavioural UART decoder ----------------
  bit         tm_act = 0;
  int         tm_cnt = 0;
  int         tm_start = 0;
  int         tm_k;
  logic [7:0] tm_byte = '0;
  txb_t       tm_exp;

  always @(negedge clk) begin
    if (rst) begin
      tm_act = 0;
    end else begin
      if (!tm_act && TX === 1'b0) begin
        tm_act   = 1;
        tm_cnt   = 0;
        tm_start = cyc;
      end
      if (tm_act) begin
        if (tm_cnt >= B / 2 && ((tm_cnt - B / 2) % B) == 0) begin
          tm_k = (tm_cnt - B / 2) / B;
          if (tm_k == 0) begin
            check("tx_start_bit", 32'(TX), 32'd0);
          end else if (tm_k <= 8) begin
            tm_byte[tm_k-1] = TX;
          end else begin
            check("tx_stop_bit", 32'(TX), 32'd1);
            if (exp_tx_q.size() == 0) begin
              fail("tx_unexpected_byte");
            end else begin
              tm_exp = exp_tx_q.pop_front();
              check("tx_byte", 32'(tm_byte), 32'(tm_exp.data));
              check("tx_frame_start", 32'(tm_start), 32'(tm_exp.start));
            end
            tm_act = 0;
          end
        end
        tm_cnt++;
      end
    end
  end

  // ---------------- cmd_cmplt and busy monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_cmplt === 1'b1) begin
        if (exp_cmplt_q.size() == 0) fail("cmplt_unexpected");
        else check("cmplt_cycle", 32'(cyc), 32'(exp_cmplt_q.pop_front()));
      end
      check("busy", 32'(busy), 32'(model_busy(cyc)));
    end
  end

  // ---------------- RX response monitor ----------------
  logic [7:0] prev_resp = 8'h00;
  logic       prev_rdy  = 1'b0;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_resp", 32'(resp), 32'h00);
      check("rst_resp_rdy", 32'(resp_rdy), 32'd0);
      prev_resp = 8'h00;
      prev_rdy  = 1'b0;
    end else begin
      if (resp !== prev_resp || (resp_rdy === 1'b1 && prev_rdy !== 1'b1)) begin
        if (exp_rx_q.size() == 0) begin
          fail("rx_unexpected_update");
        end else begin
          rx_exp = exp_rx_q.pop_front();
          check("rx_resp", 32'(resp), 32'(rx_exp));
          check("rx_resp_rdy_on_set", 32'(resp_rdy), 32'd1);
        end
      end
      prev_resp = resp;
      prev_rdy  = resp_rdy;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int m0;

  initial begin
    rst = 1'b1;
    tick(3);
    check("reset_TX", 32'(TX), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cmplt", 32'(cmd_cmplt), 32'd0);
    check("reset_resp", 32'(resp), 32'h00);
    check("reset_resp_rdy", 32'(resp_rdy), 32'd0);
    rst = 1'b0;
    tick(2);

    // Command A53C, with a second request 50 cycles in that must be dropped
    m0 = cyc;
    send_cmd(16'hA53C);
    tick(m0 + 50 - cyc);
    send_cmd(16'h1234);
    wait_tx_done();

    // Good byte, then a single-cycle clear
    send_rx(8'h96, 1'b1);
    tick(2);
    check("resp_after_96", 32'(resp), 32'(m_resp));
    check("rdy_after_96", 32'(resp_rdy), 32'(m_rdy));
    pulse_clr();
    check("rdy_after_clear", 32'(resp_rdy), 32'(m_rdy));

    // Framing error, then a short glitch on an idle line
    send_rx(8'h5A, 1'b0);
    tick(B);
    check("resp_after_framing", 32'(resp), 32'(m_resp));
    check("rdy_after_framing", 32'(resp_rdy), 32'(m_rdy));
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    tick(3 * B);
    check("resp_after_glitch", 32'(resp), 32'(m_resp));
    check("rdy_after_glitch", 32'(resp_rdy), 32'(m_rdy));

    // Overrun: two back-to-back bytes without clearing
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    tick(2);
    check("resp_overrun", 32'(resp), 32'h22);
    check("rdy_overrun", 32'(resp_rdy), 32'd1);

    // Clear held across a whole frame: the set cycle must still win
    clr_resp_rdy = 1'b1;
    send_rx(8'h33, 1'b1);
    clr_resp_rdy = 1'b0;
    m_rdy = 1'b0;
    tick(1);
    check("resp_set_vs_clear", 32'(resp), 32'h33);
    check("rdy_cleared_after_set", 32'(resp_rdy), 32'(m_rdy));

    // Reset in the middle of the high byte
    send_cmd(16'hC3A1);
    tick(60);
    rst = 1'b1;
    #1;
    check("midreset_TX", 32'(TX), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_cmplt", 32'(cmd_cmplt), 32'd0);
    exp_tx_q.delete();
    exp_cmplt_q.delete();
    acc_vld = 0;
    m_resp = 8'h00;
    m_rdy  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Fresh command after reset; a request on the cmd_cmplt cycle is dropped
    m0 = cyc;
    send_cmd(16'h00FF);
    tick(m0 + LAT - cyc);
    send_cmd(16'hBEEF);
    wait_tx_done();

    // Randomized full-duplex traffic
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_cmd(16'($urandom));
          tick(int'($urandom_range(0, 400)));
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          pulse_clr();
          send_rx(8'($urandom), $urandom_range(0, 5) != 0);
          tick(int'($urandom_range(0, 30)));
        end
      end
    join
    wait_tx_done();
    tick(2 * FRAME);

    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
    check("cmplt_queue_drained", 32'(exp_cmplt_q.size()), 32'd0);
    check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    check("final_resp", 32'(resp), 32'(m_resp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
